// File: rtl/smac_sched_pkg.sv
// rtl/smac_sched_pkg.sv - shared types and default widths for the conv layer scheduler
package smac_sched_pkg;

  localparam int FIL_W_DEF = 6;
  localparam int POS_W_DEF = 12;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sched_state_t;

endpackage

// File: rtl/smac_wrap_cnt.sv
// rtl/smac_wrap_cnt.sv - up counter with clear, terminal compare and optional saturation
module smac_wrap_cnt #(
  parameter int W   = 8,
  parameter bit SAT = 1'b0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  input  logic [W-1:0] max,
  output logic [W-1:0] value,
  output logic         at_max
);

  assign at_max = (value == max);

  // clr beats inc; at max the counter either holds (SAT) or wraps to zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value <= '0;
    end else if (clr) begin
      value <= '0;
    end else if (inc) begin
      if (!at_max) begin
        value <= value + W'(1);
      end else if (!SAT) begin
        value <= '0;
      end
    end
  end

endmodule

// File: rtl/conv_layer_sched.sv
// rtl/conv_layer_sched.sv - walks filters (inner) and output positions (outer) of one conv layer
module conv_layer_sched
  import smac_sched_pkg::*;
#(
  parameter int FIL_W = FIL_W_DEF,
  parameter int POS_W = POS_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [FIL_W-1:0] cfg_num_fil,
  input  logic [POS_W-1:0] cfg_num_pos,
  input  logic             mem_ready,
  input  logic             fil_done,
  input  logic             vol_done,
  output logic             core_stall_n,
  output logic             remW,
  output logic             last_fil,
  output logic             op_done,
  output logic [FIL_W-1:0] fil_idx,
  output logic [POS_W-1:0] pos_idx,
  output logic             busy,
  output logic             done,
  output logic             err_cfg
);

  sched_state_t     state, state_nxt;
  logic [FIL_W-1:0] num_fil_q;
  logic [POS_W-1:0] num_pos_q;
  logic             cfg_ok, start_ok, run;
  logic             fil_clr, fil_inc, fil_at_max;
  logic             pos_clr, pos_inc, pos_at_max;

  assign cfg_ok   = (cfg_num_fil != '0) && (cfg_num_pos != '0);
  assign start_ok = (state == IDLE) && start && cfg_ok && !abort;
  assign run      = (state == RUN);

  // vol_done outranks fil_done; the final vol_done leaves both indices untouched
  assign fil_clr = start_ok || abort || (run && vol_done && !op_done);
  assign fil_inc = run && fil_done && !vol_done && !abort;
  assign pos_clr = start_ok || abort;
  assign pos_inc = run && vol_done && !op_done && !abort;

  smac_wrap_cnt #(.W(FIL_W), .SAT(1'b1)) u_fil_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (fil_clr),
    .inc    (fil_inc),
    .max    (num_fil_q - FIL_W'(1)),
    .value  (fil_idx),
    .at_max (fil_at_max)
  );

  smac_wrap_cnt #(.W(POS_W), .SAT(1'b0)) u_pos_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (pos_clr),
    .inc    (pos_inc),
    .max    (num_pos_q - POS_W'(1)),
    .value  (pos_idx),
    .at_max (pos_at_max)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      num_fil_q <= '0;
      num_pos_q <= '0;
    end else begin
      state <= state_nxt;
      if (start_ok) begin
        num_fil_q <= cfg_num_fil;
        num_pos_q <= cfg_num_pos;
      end
    end
  end

  always_comb begin
    state_nxt    = state;
    core_stall_n = 1'b0;
    case (state)
      IDLE: if (start_ok) state_nxt = RUN;
      RUN: begin
        core_stall_n = mem_ready;
        if (vol_done && op_done) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (abort) state_nxt = IDLE;
  end

  // Flags trail the indices by a cycle; on start they are seeded straight from the new cfg
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_fil <= 1'b0;
      remW     <= 1'b0;
      op_done  <= 1'b0;
      err_cfg  <= 1'b0;
    end else begin
      err_cfg <= (state == IDLE) && start && !abort && !cfg_ok;
      if (start_ok) begin
        last_fil <= (cfg_num_fil == FIL_W'(1));
        remW     <= (cfg_num_fil != FIL_W'(1));
        op_done  <= (cfg_num_fil == FIL_W'(1)) && (cfg_num_pos == POS_W'(1));
      end else if (run && state_nxt == RUN) begin
        last_fil <= fil_at_max;
        remW     <= !fil_at_max;
        op_done  <= fil_at_max && pos_at_max;
      end else begin
        last_fil <= 1'b0;
        remW     <= 1'b0;
        op_done  <= 1'b0;
      end
    end
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

endmodule
